dog_extrema_detect: RTL and testbench
=====================================

Name: dog_extrema_detect

Overview:
- Sits directly downstream of the 27-sample DoG window builder (block2_27extreme).
- Consumes one 3x3x3 neighbourhood per valid beat.
- Decides whether the centre sample (scale 2, position 5) is a strict local maximum or minimum that also passes a contrast threshold and lies off the image border.
- Emits keypoint records (x, y, type, value) for the orientation/descriptor stages, plus per-frame keypoint statistics.

Parameters:
- DW, 8, DoG sample width; samples are signed two's complement.
- IMG_W, 640, image width in pixels.
- IMG_H, 480, image height in pixels.
- XW, 10, column coordinate width; must satisfy 2^XW >= IMG_W.
- YW, 9, row coordinate width; must satisfy 2^YW >= IMG_H.
- CONTRAST_TH, 3, minimum |centre| for acceptance; range 0..2^(DW-1)-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_en  in  1  window valid (driven by the window builder's out_en).
- sof  in  1  start of frame; qualified by in_en; marks pixel (0,0).
- win  in  27*DW  packed window. Sample k occupies win[DW*k +: DW], with k = (s-1)*9 + (p-1), s = scale 1..3, p = position 1..9 in row-major order. Centre is k = 13 (the builder's dout25).
- kp_valid  out  1  keypoint record valid, one-cycle pulse per keypoint.
- kp_x  out  XW  keypoint column.
- kp_y  out  YW  keypoint row.
- kp_type  out  1  1 = maximum, 0 = minimum.
- kp_val  out  DW  centre DoG value.
- frame_done  out  1  one-cycle pulse after the last pixel of a frame.
- kp_count  out  16  keypoints found in the last completed frame.

Behaviour:
- Reset (asynchronous, active-high):
  - All outputs go to 0 immediately.
  - Pipeline valid bits, coordinate counters and the running keypoint count clear.
  - After reset, the next in_en beat is pixel (0,0) even without sof.
- Beat model:
  - Exactly one in_en beat per pixel, IMG_W*IMG_H beats per frame, raster order.
  - Gaps (in_en = 0) are allowed anywhere and stall nothing; the pipeline only advances tags with data.
- Coordinate counters (x, y):
  - The beat with sof = 1 is tagged (0,0).
  - Otherwise x increments per beat. At x = IMG_W-1, x wraps to 0 and y increments.
  - At (IMG_W-1, IMG_H-1) both wrap to 0 and that beat is tagged last_pix.
  - sof while mid-frame: resynchronise to (0,0); no frame_done for the aborted frame.
- Pipeline: 3 register stages, latency exactly 3 clk from the in_en beat to kp_valid, throughput 1 window/clk. Each stage carries valid, x, y, last_pix and the centre value.
  - S1: 26 signed compares of the centre c against every neighbour n_k, k != 13.
    - gt_k = c > n_k; lt_k = c < n_k (strict).
    - contrast_ok = |c| >= CONTRAST_TH, computed on DW+1 bits so that |-2^(DW-1)| = 2^(DW-1) with no overflow.
    - border = (x == 0) | (x == IMG_W-1) | (y == 0) | (y == IMG_H-1).
  - S2: is_max = AND of all gt_k; is_min = AND of all lt_k. Both are registered with the tags.
  - S3:
    - kp_valid = v & (is_max | is_min) & contrast_ok & ~border.
    - kp_type = is_max.
    - kp_x, kp_y, kp_val are loaded only when kp_valid = 1 and hold otherwise.
- Ties: any neighbour equal to the centre makes both is_max and is_min false, so no keypoint.
- Keypoint counter:
  - A running 16-bit count increments on each kp_valid and saturates at 0xFFFF.
  - On the S3 beat carrying last_pix: frame_done pulses, kp_count loads the running count (including a keypoint on that same beat), and the running count clears.
  - kp_count holds until the next frame_done or reset.
- Reset mid-operation: in-flight windows are discarded and no partial frame_done is produced.

Decomposition:
- Shared package sift_pkg holds:
  - DW, IMG_W, IMG_H, XW, YW defaults.
  - CENTER_IDX = 13 and NB_COUNT = 26.
  - KP_MAX = 1'b1, KP_MIN = 1'b0.
  - Function win_idx(s,p) returning k.
- One sub-module, dog_cmp26: S1 compare array plus S2 AND-reduction (2 register stages), parameterised on DW; outputs is_max, is_min, contrast_ok.
- The top level holds the coordinate counters, border logic, tag pipeline, output registers and the keypoint counter.

Test Plan:
- All 27 samples = 5 at (100,50) -> kp_valid stays 0.
- Centre = 20, neighbours = 10, at (100,50) -> 3 clk later: kp_valid = 1, x = 100, y = 50, type = 1, val = 20.
- Centre = -20, neighbours = -10 -> type = 0, val = -20. Centre = -128, neighbours = 0 -> minimum accepted, no abs overflow.
- CONTRAST_TH = 3: centre = 2, neighbours = 0 -> rejected. Centre = 3 -> accepted. One neighbour (k = 4) equal to the centre = 20 -> rejected.
- Strong maximum at x = 0, then at y = IMG_H-1, then at x = IMG_W-1 -> all suppressed. Same window at (1,1) -> accepted.
- IMG_W = 8, IMG_H = 6; full frame with random in_en gaps and maxima at (3,2) and (5,4):
  - frame_done pulses once, 3 clk after the 48th beat; kp_count = 2.
  - Then assert rst mid-frame -> outputs 0 immediately; the next beat is tagged (0,0).

Source files
------------

// File: rtl/sift_pkg.sv
// Shared constants and window-indexing helper for the SIFT DoG keypoint stages.
package sift_pkg;
  localparam int DW    = 8;
  localparam int IMG_W = 640;
  localparam int IMG_H = 480;
  localparam int XW    = 10;
  localparam int YW    = 9;

  localparam int WIN_N      = 27;
  localparam int CENTER_IDX = 13;
  localparam int NB_COUNT   = 26;

  localparam logic KP_MAX = 1'b1;
  localparam logic KP_MIN = 1'b0;

  // Sample index inside the packed window for scale s (1..3), position p (1..9).
  function automatic int win_idx(input int s, input int p);
    return (s - 1) * 9 + (p - 1);
  endfunction
endpackage

// File: rtl/dog_cmp26.sv
// Centre-vs-26-neighbour compare (stage 1) and extremum AND-reduction (stage 2).
module dog_cmp26 #(
  parameter int DW          = 8,
  parameter int CONTRAST_TH = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [27*DW-1:0] win,
  output logic            is_max,
  output logic            is_min,
  output logic            contrast_ok
);
  import sift_pkg::*;

  logic signed [DW-1:0] c;
  logic [WIN_N-1:0]     gt, lt;
  logic [WIN_N-1:0]     gt_reg, lt_reg;
  logic [DW:0]          c_abs;
  logic                 ok_s1, ok_reg;

  assign c = $signed(win[DW*CENTER_IDX +: DW]);

  // The centre slot is forced to 1 so the reduction spans the whole vector.
  generate
    for (genvar gi = 0; gi < WIN_N; gi++) begin : g_cmp
      if (gi == CENTER_IDX) begin : g_ctr
        assign gt[gi] = 1'b1;
        assign lt[gi] = 1'b1;
      end else begin : g_nb
        logic signed [DW-1:0] n;
        assign n      = $signed(win[DW*gi +: DW]);
        assign gt[gi] = c > n;
        assign lt[gi] = c < n;
      end
    end
  endgenerate

  // One extra bit keeps |most-negative| representable.
  assign c_abs = c[DW-1] ? ({1'b0, ~c} + 1'b1) : {1'b0, c};
  assign ok_s1 = c_abs >= (DW+1)'(CONTRAST_TH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gt_reg      <= '0;
      lt_reg      <= '0;
      ok_reg      <= 1'b0;
      is_max      <= 1'b0;
      is_min      <= 1'b0;
      contrast_ok <= 1'b0;
    end else begin
      gt_reg      <= gt;
      lt_reg      <= lt;
      ok_reg      <= ok_s1;
      is_max      <= &gt_reg;
      is_min      <= &lt_reg;
      contrast_ok <= ok_reg;
    end
  end
endmodule

// File: rtl/dog_extrema_detect.sv
// DoG 3x3x3 extremum detector: raster tagging, 3-stage pipeline, keypoint records and per-frame count.
module dog_extrema_detect #(
  parameter int DW          = sift_pkg::DW,
  parameter int IMG_W       = sift_pkg::IMG_W,
  parameter int IMG_H       = sift_pkg::IMG_H,
  parameter int XW          = sift_pkg::XW,
  parameter int YW          = sift_pkg::YW,
  parameter int CONTRAST_TH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_en,
  input  logic             sof,
  input  logic [27*DW-1:0] win,
  output logic             kp_valid,
  output logic [XW-1:0]    kp_x,
  output logic [YW-1:0]    kp_y,
  output logic             kp_type,
  output logic [DW-1:0]    kp_val,
  output logic             frame_done,
  output logic [15:0]      kp_count
);
  import sift_pkg::*;

  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  logic [XW-1:0] x_reg, tag_x, x1_reg, x2_reg;
  logic [YW-1:0] y_reg, tag_y, y1_reg, y2_reg;
  logic          tag_last, tag_border;
  logic          v1_reg, v2_reg, last1_reg, last2_reg, border1_reg, border2_reg;
  logic [DW-1:0] c1_reg, c2_reg;
  logic          is_max, is_min, contrast_ok, hit;
  logic [15:0]   run_reg, run_inc;

  // sof overrides the free-running counters so a mid-frame sof resynchronises.
  always_comb begin
    tag_x      = sof ? '0 : x_reg;
    tag_y      = sof ? '0 : y_reg;
    tag_last   = (tag_x == X_LAST) && (tag_y == Y_LAST);
    tag_border = (tag_x == '0) || (tag_x == X_LAST) || (tag_y == '0) || (tag_y == Y_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_reg <= '0;
      y_reg <= '0;
    end else if (in_en) begin
      if (tag_x == X_LAST) begin
        x_reg <= '0;
        y_reg <= (tag_y == Y_LAST) ? '0 : tag_y + 1'b1;
      end else begin
        x_reg <= tag_x + 1'b1;
        y_reg <= tag_y;
      end
    end
  end

  dog_cmp26 #(.DW(DW), .CONTRAST_TH(CONTRAST_TH)) u_cmp (
    .clk         (clk),
    .rst         (rst),
    .win         (win),
    .is_max      (is_max),
    .is_min      (is_min),
    .contrast_ok (contrast_ok)
  );

  // Tags ride alongside the compare array's two register stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_reg <= 1'b0; x1_reg <= '0; y1_reg <= '0; last1_reg <= 1'b0; border1_reg <= 1'b0; c1_reg <= '0;
      v2_reg <= 1'b0; x2_reg <= '0; y2_reg <= '0; last2_reg <= 1'b0; border2_reg <= 1'b0; c2_reg <= '0;
    end else begin
      v1_reg      <= in_en;
      x1_reg      <= tag_x;
      y1_reg      <= tag_y;
      last1_reg   <= tag_last;
      border1_reg <= tag_border;
      c1_reg      <= win[DW*CENTER_IDX +: DW];
      v2_reg      <= v1_reg;
      x2_reg      <= x1_reg;
      y2_reg      <= y1_reg;
      last2_reg   <= last1_reg;
      border2_reg <= border1_reg;
      c2_reg      <= c1_reg;
    end
  end

  assign hit     = v2_reg & (is_max | is_min) & contrast_ok & ~border2_reg;
  assign run_inc = (run_reg == 16'hFFFF) ? run_reg : run_reg + 16'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kp_valid   <= 1'b0;
      kp_x       <= '0;
      kp_y       <= '0;
      kp_type    <= KP_MIN;
      kp_val     <= '0;
      frame_done <= 1'b0;
      kp_count   <= '0;
      run_reg    <= '0;
    end else begin
      kp_valid   <= hit;
      frame_done <= v2_reg & last2_reg;
      if (hit) begin
        kp_x    <= x2_reg;
        kp_y    <= y2_reg;
        kp_type <= is_max ? KP_MAX : KP_MIN;
        kp_val  <= c2_reg;
      end
      // The closing pixel's own keypoint is folded into the reported total.
      if (v2_reg && last2_reg) begin
        kp_count <= hit ? run_inc : run_reg;
        run_reg  <= '0;
      end else if (hit) begin
        run_reg  <= run_inc;
      end
    end
  end
endmodule

// File: tb/tb_dog_extrema_detect.sv
// Randomised bench for dog_extrema_detect on an 8x6 image against a per-beat behavioural model.
module tb_dog_extrema_detect;
  import sift_pkg::*;

  localparam int D  = 8;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int TH = 3;
  localparam int WW = 27 * D;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_en = 1'b0;
  logic          sof = 1'b0;
  logic [WW-1:0] win = '0;
  logic          kp_valid, kp_type, frame_done;
  logic [9:0]    kp_x;
  logic [8:0]    kp_y;
  logic [D-1:0]  kp_val;
  logic [15:0]   kp_count;

  dog_extrema_detect #(.DW(D), .IMG_W(W), .IMG_H(H), .XW(10), .YW(9), .CONTRAST_TH(TH)) dut (
    .clk(clk), .rst(rst), .in_en(in_en), .sof(sof), .win(win),
    .kp_valid(kp_valid), .kp_x(kp_x), .kp_y(kp_y), .kp_type(kp_type), .kp_val(kp_val),
    .frame_done(frame_done), .kp_count(kp_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_en = 0;
  int mon_cnt = 0;
  int fd_seen = 0;
  int mp = 0;
  int run = 0;

  bit exp_v[int];
  int exp_x[int], exp_y[int], exp_t[int], exp_val[int];
  bit exp_fd[int];
  int exp_cnt[int];
  logic [WW-1:0] special[int];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Reference: decide the beat's outcome from pixel index and window contents directly.
  task automatic model(input bit s, input logic [WW-1:0] w);
    int p, tx, ty, c, n, a, key;
    bit mx, mn, hit, border;
    p  = s ? 0 : mp;
    tx = p % W;
    ty = p / W;
    c  = int'($signed(w[D*CENTER_IDX +: D]));
    mx = 1;
    mn = 1;
    for (int k = 0; k < 27; k++) begin
      if (k != CENTER_IDX) begin
        n = int'($signed(w[D*k +: D]));
        if (c <= n) mx = 0;
        if (c >= n) mn = 0;
      end
    end
    a      = (c < 0) ? -c : c;
    border = (tx == 0) || (tx == W - 1) || (ty == 0) || (ty == H - 1);
    hit    = (mx || mn) && (a >= TH) && !border;
    key    = cyc + 3;
    if (hit) begin
      exp_v[key]   = 1;
      exp_x[key]   = tx;
      exp_y[key]   = ty;
      exp_t[key]   = int'(mx);
      exp_val[key] = int'(w[D*CENTER_IDX +: D]);
    end
    if (p == W * H - 1) begin
      exp_fd[key]  = 1;
      exp_cnt[key] = hit ? ((run == 65535) ? run : run + 1) : run;
      run = 0;
    end else if (hit) begin
      run = (run == 65535) ? run : run + 1;
    end
    mp = (p + 1) % (W * H);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      bit ev, ef;
      ev = exp_v.exists(cyc);
      ef = exp_fd.exists(cyc);
      check_val("kp_valid", 32'(kp_valid), 32'(ev));
      if (ev) begin
        check_val("kp_x", 32'(kp_x), exp_x[cyc]);
        check_val("kp_y", 32'(kp_y), exp_y[cyc]);
        check_val("kp_type", 32'(kp_type), exp_t[cyc]);
        check_val("kp_val", 32'(kp_val), exp_val[cyc]);
        exp_v.delete(cyc);
      end
      if (kp_valid) $display("kp     x=%0d y=%0d type=%0d val=%0d", kp_x, kp_y, kp_type, $signed(kp_val));
      if (ef) begin
        mon_cnt = exp_cnt[cyc];
        exp_fd.delete(cyc);
      end
      check_val("frame_done", 32'(frame_done), 32'(ef));
      check_val("kp_count", 32'(kp_count), mon_cnt);
      if (frame_done) begin
        fd_seen++;
        $display("frame  done kp_count=%0d", kp_count);
      end
    end
  end

  function automatic logic [WW-1:0] uni(input int c, input int n);
    logic [WW-1:0] w;
    for (int k = 0; k < 27; k++) w[D*k +: D] = (k == CENTER_IDX) ? D'(c) : D'(n);
    return w;
  endfunction

  function automatic logic [WW-1:0] rnd_win();
    logic [WW-1:0] w;
    int cv;
    for (int k = 0; k < 27; k++) w[D*k +: D] = D'($urandom);
    if ($urandom_range(0, 2) == 0) begin
      cv = ($urandom_range(0, 1) == 1) ? 100 : -100;
      for (int k = 0; k < 27; k++) w[D*k +: D] = D'(int'($urandom_range(0, 180)) - 90);
      w[D*CENTER_IDX +: D] = D'(cv);
    end
    return w;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input bit s, input logic [WW-1:0] w, input bit gaps);
    model(s, w);
    in_en = 1'b1;
    sof   = s;
    win   = w;
    @(posedge clk);
    #1;
    in_en = 1'b0;
    sof   = 1'b0;
    if (gaps) idle($urandom_range(0, 2));
  endtask

  task automatic run_beats(input int n, input bit first_sof, input bit rnd_bg, input bit gaps);
    logic [WW-1:0] w;
    for (int p = 0; p < n; p++) begin
      if (special.exists(p)) w = special[p];
      else if (rnd_bg) w = rnd_win();
      else w = uni(0, 0);
      send(first_sof && (p == 0), w, gaps);
    end
  endtask

  task automatic do_reset();
    #1 rst = 1'b1;
    #1;
    check_val("rst_kp_valid", 32'(kp_valid), 0);
    check_val("rst_kp_x", 32'(kp_x), 0);
    check_val("rst_kp_y", 32'(kp_y), 0);
    check_val("rst_kp_type", 32'(kp_type), 0);
    check_val("rst_kp_val", 32'(kp_val), 0);
    check_val("rst_frame_done", 32'(frame_done), 0);
    check_val("rst_kp_count", 32'(kp_count), 0);
    exp_v.delete();
    exp_fd.delete();
    mon_cnt = 0;
    mp = 0;
    run = 0;
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [WW-1:0] w;
    int fd_before;
    rst = 1'b1;
    #7;
    check_val("init_kp_valid", 32'(kp_valid), 0);
    check_val("init_frame_done", 32'(frame_done), 0);
    check_val("init_kp_count", 32'(kp_count), 0);
    #5 rst = 1'b0;
    @(posedge clk);
    #1;
    mon_en = 1;

    // Directed frame: contrast, sign, tie and border cases at known pixels.
    special.delete();
    special[2*W+3] = uni(5, 5);
    special[2*W+4] = uni(20, 10);
    special[2*W+5] = uni(-20, -10);
    special[2*W+6] = uni(-128, 0);
    special[3*W+1] = uni(2, 0);
    special[3*W+2] = uni(3, 0);
    w = uni(20, 10);
    w[D*win_idx(1, 5) +: D] = D'(20);
    special[3*W+3] = w;
    special[4*W+0] = uni(100, 0);
    special[5*W+3] = uni(100, 0);
    special[4*W+7] = uni(100, 0);
    special[1*W+1] = uni(100, 0);
    run_beats(W * H, 1, 0, 0);
    idle(6);
    check_val("frameA_count", 32'(kp_count), 5);

    // Sparse frame with random gaps: exactly two maxima, one frame_done.
    special.delete();
    special[2*W+3] = uni(50, 7);
    special[4*W+5] = uni(60, -3);
    fd_before = fd_seen;
    run_beats(W * H, 1, 0, 1);
    idle(6);
    check_val("frameB_count", 32'(kp_count), 2);
    check_val("frameB_done_pulses", 32'(fd_seen - fd_before), 1);

    // Random frames with gaps, then an aborted frame resynchronised by sof.
    special.delete();
    run_beats(W * H, 1, 1, 1);
    run_beats(W * H, 1, 1, 1);
    run_beats(13, 0, 1, 1);
    run_beats(W * H, 1, 1, 1);
    idle(6);

    // Mid-frame reset: the first beat afterwards must be (0,0) without sof.
    run_beats(20, 1, 1, 0);
    do_reset();
    special.delete();
    special[1*W+1] = uni(90, 1);
    run_beats(W * H, 0, 0, 1);
    idle(6);
    check_val("post_rst_count", 32'(kp_count), 1);

    special.delete();
    run_beats(W * H, 0, 1, 1);
    idle(8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
